// File: rtl/yarp_pkg.sv
// Shared types for the yarp memory arbiter.
//   arb_state_e : arbiter FSM state (IDLE = nothing outstanding, WAIT = one
//                 transaction outstanding)
//   arb_owner_e : which requester owns the outstanding transaction
//   FETCH_BE    : byte enables driven for instruction fetches
//   STARVE_W    : width of the fetch starvation counter
package yarp_pkg;

  typedef enum logic {ARB_IDLE, ARB_WAIT} arb_state_e;

  typedef enum logic [1:0] {OWN_NONE, OWN_INSTR, OWN_DATA} arb_owner_e;

  localparam logic [3:0] FETCH_BE = 4'hF;
  localparam int         STARVE_W = 4;

endpackage

// File: rtl/yarp_arb_sel.sv
// Combinational winner selection for the memory arbiter.
//   imem_req_i   : fetch request pending
//   dmem_req_i   : data request pending
//   starve_hit_i : starvation counter has reached its limit
//   winner_o     : requester that would be granted this cycle (OWN_NONE if none)
// Data normally wins; a starved fetch overrides data.
module yarp_arb_sel
  import yarp_pkg::*;
(
  input  logic       imem_req_i,
  input  logic       dmem_req_i,
  input  logic       starve_hit_i,
  output arb_owner_e winner_o
);

  always_comb begin
    winner_o = OWN_NONE;
    if (starve_hit_i && imem_req_i) begin
      winner_o = OWN_INSTR;
    end else if (dmem_req_i) begin
      winner_o = OWN_DATA;
    end else if (imem_req_i) begin
      winner_o = OWN_INSTR;
    end
  end

endmodule

// File: rtl/yarp_mem_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store.
// At most one transaction is outstanding; the response is routed back to the
// requester that was granted. Grant and response paths are combinational.
//
// Handshake: a requester raises *_req_i with a stable payload and holds it
// until the cycle in which *_gnt_o is high; that cycle transfers the request.
// The memory side accepts mem_req_o in any cycle where mem_gnt_i is high, and
// answers with a single mem_rvalid_i pulse one or more cycles later.
//
// Ports:
//   clk, reset            : clock, asynchronous active-low reset
//   imem_*                : fetch request / grant / response
//   dmem_*                : load-store request / grant / response
//   mem_*                 : memory-side request / grant / response
//   mem_err_o             : sticky, response seen with nothing outstanding
//   dbg_state_o/owner_o/starve_o : internal FSM state, owner, starve counter
module yarp_mem_arbiter
  import yarp_pkg::*;
#(
  parameter int unsigned DATA_BURST_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                imem_req_i,
  input  logic [31:0]         imem_addr_i,
  output logic                imem_gnt_o,
  output logic                imem_rvalid_o,
  output logic [31:0]         imem_rdata_o,
  input  logic                dmem_req_i,
  input  logic [31:0]         dmem_addr_i,
  input  logic                dmem_we_i,
  input  logic [3:0]          dmem_be_i,
  input  logic [31:0]         dmem_wdata_i,
  output logic                dmem_gnt_o,
  output logic                dmem_rvalid_o,
  output logic [31:0]         dmem_rdata_o,
  output logic                mem_req_o,
  output logic [31:0]         mem_addr_o,
  output logic                mem_we_o,
  output logic [3:0]          mem_be_o,
  output logic [31:0]         mem_wdata_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [31:0]         mem_rdata_i,
  output logic                mem_err_o,
  output arb_state_e          dbg_state_o,
  output arb_owner_e          dbg_owner_o,
  output logic [STARVE_W-1:0] dbg_starve_o
);

  localparam logic [STARVE_W-1:0] BURST_MAX = STARVE_W'(DATA_BURST_MAX);

  arb_state_e          state_q, state_d;
  arb_owner_e          owner_q, owner_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                err_q, err_d;

  arb_owner_e sel_winner;
  arb_owner_e winner;
  logic       idle;
  logic       accept;

  assign idle = (state_q == ARB_IDLE);

  yarp_arb_sel u_sel (
    .imem_req_i   (imem_req_i),
    .dmem_req_i   (dmem_req_i),
    .starve_hit_i (starve_q == BURST_MAX),
    .winner_o     (sel_winner)
  );

  // No winner exists while a transaction is outstanding.
  assign winner = idle ? sel_winner : OWN_NONE;

  assign mem_req_o = idle && (imem_req_i || dmem_req_i);
  assign accept    = mem_req_o && mem_gnt_i;

  always_comb begin
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    case (winner)
      OWN_DATA: begin
        mem_addr_o  = dmem_addr_i;
        mem_we_o    = dmem_we_i;
        mem_be_o    = dmem_be_i;
        mem_wdata_o = dmem_wdata_i;
      end
      OWN_INSTR: begin
        mem_addr_o = imem_addr_i;
        mem_be_o   = FETCH_BE;
      end
      default: ;
    endcase
  end

  assign imem_gnt_o    = accept && (winner == OWN_INSTR);
  assign dmem_gnt_o    = accept && (winner == OWN_DATA);
  assign imem_rvalid_o = !idle && mem_rvalid_i && (owner_q == OWN_INSTR);
  assign dmem_rvalid_o = !idle && mem_rvalid_i && (owner_q == OWN_DATA);
  assign imem_rdata_o  = imem_rvalid_o ? mem_rdata_i : '0;
  assign dmem_rdata_o  = dmem_rvalid_o ? mem_rdata_i : '0;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    starve_d = starve_q;
    err_d    = err_q;
    case (state_q)
      ARB_IDLE: begin
        // A response with nothing outstanding is a protocol error.
        if (mem_rvalid_i) err_d = 1'b1;
        if (accept) begin
          state_d = ARB_WAIT;
          owner_d = winner;
          if (winner == OWN_DATA) begin
            // Count data grants that overtook a waiting fetch.
            if (!imem_req_i)                starve_d = '0;
            else if (starve_q < BURST_MAX)  starve_d = starve_q + 1'b1;
          end else begin
            starve_d = '0;
          end
        end
      end
      ARB_WAIT: begin
        if (mem_rvalid_i) begin
          state_d = ARB_IDLE;
          owner_d = OWN_NONE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ARB_IDLE;
      owner_q  <= OWN_NONE;
      starve_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
      err_q    <= err_d;
    end
  end

  assign mem_err_o    = err_q;
  assign dbg_state_o  = state_q;
  assign dbg_owner_o  = owner_q;
  assign dbg_starve_o = starve_q;

endmodule
